// File: rtl/rpc_echo_copy_engine.sv
// Per-flow RPC echo engine: reads a request header and payload from the rx ring,
// writes the echoed (or pattern-filled) response into the tx ring, then advances both pointers.
module rpc_echo_copy_engine #(
  parameter int DATA_W    = 256,
  parameter int FLOW_ID_W = 8,
  parameter int PTR_W     = 14,
  parameter int ECHO_MODE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flow_val,
  input  logic [FLOW_ID_W-1:0]            flow_id,
  output logic                            flow_rdy,
  output logic                            requeue_val,
  input  logic                            requeue_rdy,
  output logic [FLOW_ID_W-1:0]            cur_flowid,
  input  logic [PTR_W:0]                  rx_head_ptr,
  input  logic [PTR_W:0]                  rx_commit_ptr,
  input  logic [PTR_W:0]                  tx_head_ptr,
  input  logic [PTR_W:0]                  tx_tail_ptr,
  output logic                            ptr_wr_val,
  output logic [PTR_W:0]                  ptr_wr_rx_head,
  output logic [PTR_W:0]                  ptr_wr_tx_tail,
  output logic                            rd_req_val,
  input  logic                            rd_req_rdy,
  output logic [PTR_W:0]                  rd_req_offset,
  output logic [15:0]                     rd_req_size,
  input  logic                            rd_data_val,
  output logic                            rd_data_rdy,
  input  logic [DATA_W-1:0]               rd_data,
  input  logic                            rd_data_last,
  output logic                            wr_req_val,
  input  logic                            wr_req_rdy,
  output logic [PTR_W:0]                  wr_req_ptr,
  output logic [15:0]                     wr_req_size,
  output logic                            wr_data_val,
  input  logic                            wr_data_rdy,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            wr_data_last,
  output logic [$clog2(DATA_W/8)-1:0]     wr_data_padbytes
);
  localparam int HB   = DATA_W / 8;
  localparam int PADW = $clog2(HB);
  localparam int PW   = PTR_W + 1;
  localparam int CW   = (PTR_W + 2 > 17) ? PTR_W + 2 : 17;
  localparam bit ECHO = (ECHO_MODE != 0);
  localparam logic [PTR_W:0]    HB_P = HB[PTR_W:0];
  localparam logic [15:0]       HB16 = HB[15:0];
  localparam logic [DATA_W-1:0] FILL = {HB{8'hA5}};

  typedef enum logic [3:0] {
    S_IDLE, S_PTR, S_HDR_CHK, S_HDR_REQ, S_HDR_DATA,
    S_SAT_CHK, S_XFER_REQ, S_STREAM, S_UPDATE, S_REQUEUE
  } state_t;

  state_t         state, next;
  logic [PTR_W:0] rx_head, rx_commit, tx_head, tx_tail;
  logic [15:0]    rd_len, wr_len, bytes_left;
  logic           rd_req_done, wr_req_done, rd_end, wr_end;

  logic [PTR_W:0] rx_used, tx_used;
  logic [15:0]    out_len;
  logic [CW-1:0]  rx_avail, tx_free, tx_cap;
  logic           sat_ok, rd_beat, wr_beat;

  assign rx_used  = rx_commit - rx_head;
  assign tx_used  = tx_tail - tx_head;
  assign out_len  = ECHO ? rd_len : wr_len;
  assign tx_cap   = CW'(1) << PTR_W;
  // only evaluated in SAT_CHK, where rx_used >= HB is already established
  assign rx_avail = CW'(rx_used - HB_P);
  assign tx_free  = tx_cap - CW'(tx_used);
  assign sat_ok   = (rx_avail >= CW'(rd_len)) && (CW'(tx_used) <= tx_cap) &&
                    (tx_free >= CW'(out_len));

  assign rd_beat = rd_data_val && rd_data_rdy;
  assign wr_beat = wr_data_val && wr_data_rdy;

  assign ptr_wr_rx_head   = rx_head + HB_P + PW'(rd_len);
  assign ptr_wr_tx_tail   = tx_tail + PW'(out_len);
  assign wr_data          = ECHO ? rd_data : FILL;
  assign wr_data_last     = ECHO ? rd_data_last : (bytes_left <= HB16);
  assign wr_data_padbytes = '0 - out_len[PADW-1:0];

  always_comb begin
    next          = state;
    flow_rdy      = 1'b0;
    requeue_val   = 1'b0;
    ptr_wr_val    = 1'b0;
    rd_req_val    = 1'b0;
    rd_req_offset = rx_head + HB_P;
    rd_req_size   = rd_len;
    wr_req_val    = 1'b0;
    wr_req_ptr    = tx_tail;
    wr_req_size   = out_len;
    rd_data_rdy   = 1'b0;
    wr_data_val   = 1'b0;
    case (state)
      S_IDLE: begin
        flow_rdy = 1'b1;
        if (flow_val) next = S_PTR;
      end
      S_PTR:     next = S_HDR_CHK;
      S_HDR_CHK: next = (rx_used < HB_P) ? S_REQUEUE : S_HDR_REQ;
      S_HDR_REQ: begin
        rd_req_val    = 1'b1;
        rd_req_offset = rx_head;
        rd_req_size   = HB16;
        if (rd_req_rdy) next = S_HDR_DATA;
      end
      S_HDR_DATA: begin
        rd_data_rdy = 1'b1;
        if (rd_data_val) next = S_SAT_CHK;
      end
      S_SAT_CHK: next = sat_ok ? S_XFER_REQ : S_REQUEUE;
      S_XFER_REQ: begin
        rd_req_val = !rd_req_done;
        wr_req_val = !wr_req_done;
        if ((rd_req_done || rd_req_rdy) && (wr_req_done || wr_req_rdy)) next = S_STREAM;
      end
      S_STREAM: begin
        if (ECHO) begin
          rd_data_rdy = !rd_end && wr_data_rdy;
          wr_data_val = !wr_end && rd_data_val;
        end else begin
          rd_data_rdy = 1'b1;
          wr_data_val = !wr_end;
        end
        if (rd_end && wr_end) next = S_UPDATE;
      end
      S_UPDATE: begin
        ptr_wr_val = 1'b1;
        next       = S_REQUEUE;
      end
      S_REQUEUE: begin
        requeue_val = 1'b1;
        if (requeue_rdy) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_flowid  <= '0;
      rx_head     <= '0;
      rx_commit   <= '0;
      tx_head     <= '0;
      tx_tail     <= '0;
      rd_len      <= '0;
      wr_len      <= '0;
      bytes_left  <= '0;
      rd_req_done <= 1'b0;
      wr_req_done <= 1'b0;
      rd_end      <= 1'b0;
      wr_end      <= 1'b0;
    end else begin
      state <= next;
      case (state)
        S_IDLE: if (flow_val) cur_flowid <= flow_id;
        S_PTR: begin
          rx_head   <= rx_head_ptr;
          rx_commit <= rx_commit_ptr;
          tx_head   <= tx_head_ptr;
          tx_tail   <= tx_tail_ptr;
        end
        S_HDR_DATA: if (rd_data_val) begin
          rd_len <= rd_data[DATA_W-1 -: 16];
          wr_len <= rd_data[DATA_W-17 -: 16];
        end
        // zero-length sides are marked finished up front so they are never requested or awaited
        S_SAT_CHK: begin
          rd_req_done <= (rd_len == '0);
          wr_req_done <= (out_len == '0);
          rd_end      <= (rd_len == '0);
          wr_end      <= (out_len == '0);
          bytes_left  <= wr_len;
        end
        S_XFER_REQ: begin
          if (rd_req_val && rd_req_rdy) rd_req_done <= 1'b1;
          if (wr_req_val && wr_req_rdy) wr_req_done <= 1'b1;
        end
        S_STREAM: begin
          if (rd_beat && rd_data_last) rd_end <= 1'b1;
          if (wr_beat) begin
            bytes_left <= bytes_left - HB16;
            if (wr_data_last) wr_end <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rpc_echo_copy_engine.sv
// Scoreboard bench: an echo-mode and a fill-mode engine share the memory/buffer models;
// expected transfers are queued from a reference model and checked as the engine emits them.
module tb_rpc_echo_copy_engine;
  localparam int DW = 256, FW = 8, PW = 14, HB = 32, P1 = PW + 1;
  localparam logic [DW-1:0] FILL = {32{8'hA5}};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic fv = 1'b0, sel = 1'b1;
  logic [FW-1:0] flow_id = '0;
  logic requeue_rdy = 1'b0, rd_req_rdy = 1'b0, wr_req_rdy = 1'b0, wr_data_rdy = 1'b0;
  logic rd_data_val = 1'b0, rd_data_last = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [P1-1:0] rx_head_ptr = '0, rx_commit_ptr = '0, tx_head_ptr = '0, tx_tail_ptr = '0;
  logic flow_val0, flow_val1;
  assign flow_val1 = fv && sel;
  assign flow_val0 = fv && !sel;

  // per-instance outputs
  logic flow_rdy0, requeue_val0, ptr_wr_val0, rd_req_val0, rd_data_rdy0, wr_req_val0, wr_data_val0, wr_data_last0;
  logic flow_rdy1, requeue_val1, ptr_wr_val1, rd_req_val1, rd_data_rdy1, wr_req_val1, wr_data_val1, wr_data_last1;
  logic [FW-1:0] cur_flowid0, cur_flowid1;
  logic [P1-1:0] ptr_wr_rx_head0, ptr_wr_tx_tail0, rd_req_offset0, wr_req_ptr0;
  logic [P1-1:0] ptr_wr_rx_head1, ptr_wr_tx_tail1, rd_req_offset1, wr_req_ptr1;
  logic [15:0] rd_req_size0, wr_req_size0, rd_req_size1, wr_req_size1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [4:0] wr_data_padbytes0, wr_data_padbytes1;

  rpc_echo_copy_engine #(.DATA_W(DW), .FLOW_ID_W(FW), .PTR_W(PW), .ECHO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flow_val(flow_val1), .flow_id(flow_id), .flow_rdy(flow_rdy1),
    .requeue_val(requeue_val1), .requeue_rdy(requeue_rdy), .cur_flowid(cur_flowid1),
    .rx_head_ptr(rx_head_ptr), .rx_commit_ptr(rx_commit_ptr), .tx_head_ptr(tx_head_ptr), .tx_tail_ptr(tx_tail_ptr),
    .ptr_wr_val(ptr_wr_val1), .ptr_wr_rx_head(ptr_wr_rx_head1), .ptr_wr_tx_tail(ptr_wr_tx_tail1),
    .rd_req_val(rd_req_val1), .rd_req_rdy(rd_req_rdy), .rd_req_offset(rd_req_offset1), .rd_req_size(rd_req_size1),
    .rd_data_val(rd_data_val), .rd_data_rdy(rd_data_rdy1), .rd_data(rd_data), .rd_data_last(rd_data_last),
    .wr_req_val(wr_req_val1), .wr_req_rdy(wr_req_rdy), .wr_req_ptr(wr_req_ptr1), .wr_req_size(wr_req_size1),
    .wr_data_val(wr_data_val1), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data1), .wr_data_last(wr_data_last1),
    .wr_data_padbytes(wr_data_padbytes1));

  rpc_echo_copy_engine #(.DATA_W(DW), .FLOW_ID_W(FW), .PTR_W(PW), .ECHO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flow_val(flow_val0), .flow_id(flow_id), .flow_rdy(flow_rdy0),
    .requeue_val(requeue_val0), .requeue_rdy(requeue_rdy), .cur_flowid(cur_flowid0),
    .rx_head_ptr(rx_head_ptr), .rx_commit_ptr(rx_commit_ptr), .tx_head_ptr(tx_head_ptr), .tx_tail_ptr(tx_tail_ptr),
    .ptr_wr_val(ptr_wr_val0), .ptr_wr_rx_head(ptr_wr_rx_head0), .ptr_wr_tx_tail(ptr_wr_tx_tail0),
    .rd_req_val(rd_req_val0), .rd_req_rdy(rd_req_rdy), .rd_req_offset(rd_req_offset0), .rd_req_size(rd_req_size0),
    .rd_data_val(rd_data_val), .rd_data_rdy(rd_data_rdy0), .rd_data(rd_data), .rd_data_last(rd_data_last),
    .wr_req_val(wr_req_val0), .wr_req_rdy(wr_req_rdy), .wr_req_ptr(wr_req_ptr0), .wr_req_size(wr_req_size0),
    .wr_data_val(wr_data_val0), .wr_data_rdy(wr_data_rdy), .wr_data(wr_data0), .wr_data_last(wr_data_last0),
    .wr_data_padbytes(wr_data_padbytes0));

  // view of the engine under test
  logic m_flow_rdy, m_requeue_val, m_ptr_wr_val, m_rd_req_val, m_rd_data_rdy, m_wr_req_val, m_wr_data_val, m_wr_data_last;
  logic [FW-1:0] m_cur_flowid;
  logic [P1-1:0] m_ptr_wr_rx_head, m_ptr_wr_tx_tail, m_rd_req_offset, m_wr_req_ptr;
  logic [15:0] m_rd_req_size, m_wr_req_size;
  logic [DW-1:0] m_wr_data;
  logic [4:0] m_wr_data_padbytes;
  always_comb begin
    m_flow_rdy = sel ? flow_rdy1 : flow_rdy0;
    m_requeue_val = sel ? requeue_val1 : requeue_val0;
    m_ptr_wr_val = sel ? ptr_wr_val1 : ptr_wr_val0;
    m_rd_req_val = sel ? rd_req_val1 : rd_req_val0;
    m_rd_data_rdy = sel ? rd_data_rdy1 : rd_data_rdy0;
    m_wr_req_val = sel ? wr_req_val1 : wr_req_val0;
    m_wr_data_val = sel ? wr_data_val1 : wr_data_val0;
    m_wr_data_last = sel ? wr_data_last1 : wr_data_last0;
    m_cur_flowid = sel ? cur_flowid1 : cur_flowid0;
    m_ptr_wr_rx_head = sel ? ptr_wr_rx_head1 : ptr_wr_rx_head0;
    m_ptr_wr_tx_tail = sel ? ptr_wr_tx_tail1 : ptr_wr_tx_tail0;
    m_rd_req_offset = sel ? rd_req_offset1 : rd_req_offset0;
    m_wr_req_ptr = sel ? wr_req_ptr1 : wr_req_ptr0;
    m_rd_req_size = sel ? rd_req_size1 : rd_req_size0;
    m_wr_req_size = sel ? wr_req_size1 : wr_req_size0;
    m_wr_data = sel ? wr_data1 : wr_data0;
    m_wr_data_padbytes = sel ? wr_data_padbytes1 : wr_data_padbytes0;
  end

  int checks = 0, passes = 0;
  int rq_seen = 0, ptr_seen = 0, wb_seen = 0;
  logic [P1-1:0] a_rxh [256], a_rxc [256], a_txh [256], a_txt [256];
  logic [511:0] q_rd[$], q_wr[$], q_wb[$], q_ptr[$], q_rq[$];
  logic [DW:0] beats[$], pay_beats[$];
  logic [DW-1:0] hdr_beat;
  bit hdr_pend = 1'b0, rd_acc = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm, input logic [511:0] act);
    checks++;
    $display("FAIL %s: got %0h required no transfer", nm, act);
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin a_rxh[i] = '0; a_rxc[i] = '0; a_txh[i] = '0; a_txt[i] = '0; end
  end

  // pointer memory (1-cycle read), random ready pressure and rx beat source
  initial forever begin
    @(posedge clk); #1;
    rx_head_ptr = a_rxh[m_cur_flowid];
    rx_commit_ptr = a_rxc[m_cur_flowid];
    tx_head_ptr = a_txh[m_cur_flowid];
    tx_tail_ptr = a_txt[m_cur_flowid];
    rd_req_rdy = ($urandom_range(0, 3) != 0);
    wr_req_rdy = ($urandom_range(0, 3) != 0);
    wr_data_rdy = ($urandom_range(0, 3) != 0);
    requeue_rdy = ($urandom_range(0, 2) != 0);
    if (!(rd_data_val && !rd_acc)) begin
      rd_data_val = 1'b0;
      if (beats.size() > 0 && $urandom_range(0, 3) != 0) begin
        {rd_data, rd_data_last} = beats.pop_front();
        rd_data_val = 1'b1;
      end
    end
  end

  // monitor: inputs settle #1 after posedge, so negedge values are what the next edge sees
  initial forever begin
    @(negedge clk);
    rd_acc = rd_data_val && m_rd_data_rdy;
    if (m_rd_req_val && rd_req_rdy) begin
      if (q_rd.size() == 0) unexpected("rd_req", 512'({m_rd_req_offset, m_rd_req_size}));
      else chk("rd_req", 512'({m_rd_req_offset, m_rd_req_size}), q_rd.pop_front());
      if (hdr_pend) begin beats.push_back({hdr_beat, 1'b1}); hdr_pend = 1'b0; end
      else while (pay_beats.size() > 0) beats.push_back(pay_beats.pop_front());
    end
    if (m_wr_req_val && wr_req_rdy) begin
      if (q_wr.size() == 0) unexpected("wr_req", 512'({m_wr_req_ptr, m_wr_req_size}));
      else chk("wr_req", 512'({m_wr_req_ptr, m_wr_req_size}), q_wr.pop_front());
    end
    if (m_wr_data_val && wr_data_rdy) begin
      wb_seen++;
      if (q_wb.size() == 0) unexpected("wr_beat", 512'({m_wr_data, m_wr_data_last, m_wr_data_padbytes}));
      else chk("wr_beat", 512'({m_wr_data, m_wr_data_last, m_wr_data_padbytes}), q_wb.pop_front());
    end
    if (m_ptr_wr_val) begin
      ptr_seen++;
      if (q_ptr.size() == 0) unexpected("ptr_wr", 512'({m_ptr_wr_rx_head, m_ptr_wr_tx_tail}));
      else chk("ptr_wr", 512'({m_ptr_wr_rx_head, m_ptr_wr_tx_tail}), q_ptr.pop_front());
    end
    if (m_requeue_val && requeue_rdy) begin
      rq_seen++;
      if (q_rq.size() == 0) unexpected("requeue", 512'(m_cur_flowid));
      else chk("requeue", 512'(m_cur_flowid), q_rq.pop_front());
    end
  end

  // reference model: derive every expected transfer from pointers and header lengths
  task automatic prep_txn(input bit s, input logic [FW-1:0] f, input logic [P1-1:0] rxh, rxc, txh, txt,
                          input logic [15:0] rdl, wrl);
    logic [P1-1:0] t;
    logic [DW-1:0] d;
    logic [4:0] pad;
    int ru, tu, outl, nb;
    sel = s;
    a_rxh[f] = rxh; a_rxc[f] = rxc; a_txh[f] = txh; a_txt[f] = txt;
    pay_beats.delete();
    d = rand_beat();
    d[DW-1 -: 16] = rdl;
    d[DW-17 -: 16] = wrl;
    hdr_beat = d;
    t = rxc - rxh; ru = int'(t);
    t = txt - txh; tu = int'(t);
    outl = s ? int'(rdl) : int'(wrl);
    hdr_pend = (ru >= HB);
    if (ru >= HB) begin
      q_rd.push_back(512'({rxh, 16'(HB)}));
      if ((ru - HB >= int'(rdl)) && ((1 << PW) - tu >= outl)) begin
        pad = (outl % HB == 0) ? 5'd0 : 5'(HB - outl % HB);
        if (rdl != 0) q_rd.push_back(512'({P1'(int'(rxh) + HB), rdl}));
        if (outl != 0) q_wr.push_back(512'({txt, 16'(outl)}));
        nb = (int'(rdl) + HB - 1) / HB;
        for (int i = 0; i < nb; i++) begin
          d = rand_beat();
          pay_beats.push_back({d, i == nb - 1});
          if (s) q_wb.push_back(512'({d, i == nb - 1, pad}));
        end
        if (!s) begin
          nb = (int'(wrl) + HB - 1) / HB;
          for (int i = 0; i < nb; i++) q_wb.push_back(512'({FILL, i == nb - 1, pad}));
        end
        q_ptr.push_back(512'({P1'(int'(rxh) + HB + int'(rdl)), P1'(int'(txt) + outl)}));
      end
    end
    q_rq.push_back(512'(f));
  endtask

  task automatic flush_all();
    q_rd.delete(); q_wr.delete(); q_wb.delete(); q_ptr.delete(); q_rq.delete();
    beats.delete(); pay_beats.delete(); hdr_pend = 1'b0; rd_data_val = 1'b0; fv = 1'b0;
  endtask

  task automatic recover();
    @(posedge clk); #2; rst = 1'b1; flush_all();
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic offer(input logic [FW-1:0] f);
    bit acc = 1'b0;
    fv = 1'b1; flow_id = f;
    for (int n = 0; n < 50 && !acc; n++) begin @(negedge clk); acc = m_flow_rdy; end
    @(posedge clk); #2; fv = 1'b0;
    if (!acc) begin checks++; $display("FAIL flow_accept: got flow_rdy=0 for 50 cycles, required 1"); end
  endtask

  task automatic run_txn(input bit s, input logic [FW-1:0] f, input logic [P1-1:0] rxh, rxc, txh, txt,
                         input logic [15:0] rdl, wrl);
    int rq0;
    @(posedge clk); #2;
    prep_txn(s, f, rxh, rxc, txh, txt, rdl, wrl);
    rq0 = rq_seen;
    offer(f);
    for (int n = 0; n < 1000 && rq_seen == rq0; n++) @(negedge clk);
    if (rq_seen == rq0) begin
      checks++;
      $display("FAIL txn_done: got no requeue within 1000 cycles, required requeue of flow %0d", f);
      recover();
    end else begin
      chk("drained", 512'(q_rd.size() + q_wr.size() + q_wb.size() + q_ptr.size() + q_rq.size() + beats.size()), '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P1-1:0] rxh, txh, used, txu;
    logic [15:0] rdl, wrl;
    int r, b0, p0, q0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs1", 512'({requeue_val1, ptr_wr_val1, rd_req_val1, wr_req_val1, wr_data_val1, rd_data_rdy1, cur_flowid1}), '0);
    chk("reset_outs0", 512'({requeue_val0, ptr_wr_val0, rd_req_val0, wr_req_val0, wr_data_val0, rd_data_rdy0, cur_flowid0}), '0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("flow_rdy_after_reset", 512'({flow_rdy1, flow_rdy0}), 512'(2'b11));

    run_txn(1'b1, 8'd5, 15'd0, 15'd96, 15'd0, 15'd0, 16'd64, 16'd0);
    run_txn(1'b1, 8'd6, 15'd100, 15'd116, 15'd0, 15'd0, 16'd64, 16'd0);
    run_txn(1'b1, 8'd7, 15'd0, 15'd72, 15'd0, 15'(16384 - 16), 16'd40, 16'd0);
    run_txn(1'b0, 8'd8, 15'd200, 15'd232, 15'd10, 15'd10, 16'd0, 16'd40);
    run_txn(1'b1, 8'd9, 15'(32768 - 32), 15'd32, 15'd0, 15'd0, 16'd32, 16'd0);

    for (int k = 0; k < 40; k++) begin
      rxh = 15'($urandom); txh = 15'($urandom);
      rdl = 16'($urandom_range(0, 260)); wrl = 16'($urandom_range(0, 260));
      r = $urandom_range(0, 5);
      if (r == 0) used = 15'($urandom_range(0, 31));
      else if (r == 1) used = 15'($urandom_range(32, 200));
      else used = 15'(32 + int'(rdl) + $urandom_range(0, 64));
      txu = ($urandom_range(0, 5) == 0) ? 15'($urandom_range(16100, 16384)) : 15'($urandom_range(0, 2000));
      run_txn(k[0], 8'($urandom), rxh, rxh + used, txh, txh + txu, rdl, wrl);
    end

    // abandon a transfer mid-stream
    @(posedge clk); #2;
    prep_txn(1'b1, 8'd11, 15'd100, 15'd500, 15'd0, 15'd0, 16'd256, 16'd0);
    b0 = wb_seen;
    offer(8'd11);
    for (int n = 0; n < 400 && wb_seen == b0; n++) @(negedge clk);
    if (wb_seen == b0) begin checks++; $display("FAIL abort_stream: got no wr beat in 400 cycles, required one"); end
    @(posedge clk); #2;
    rst = 1'b1; flush_all();
    p0 = ptr_seen; q0 = rq_seen;
    #1;
    chk("abort_idle", 512'({m_flow_rdy, m_ptr_wr_val, m_requeue_val, m_wr_data_val, m_rd_req_val, m_rd_data_rdy}), 512'(6'b100000));
    @(posedge clk); #2; rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_update", 512'((ptr_seen - p0) + (rq_seen - q0)), '0);
    chk("abort_flow_rdy", 512'(m_flow_rdy), 512'(1'b1));
    run_txn(1'b1, 8'd12, 15'd64, 15'd160, 15'd8, 15'd8, 16'd64, 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rpc_echo_copy_engine.md
RPC_ECHO_COPY_ENGINE -- requirements
Module: rpc_echo_copy_engine

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 256, NoC beat width in bits; header = one beat; HB = DATA_W/8 bytes.
- FLOW_ID_W, 8, flow id width.
- PTR_W, 14, log2 buffer bytes; pointers are PTR_W+1 bits, wrap mod 2^(PTR_W+1).
- ECHO_MODE, 1, 1 = copy request payload to tx; 0 = legacy fill of wr_len pattern bytes.

REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports, one per line:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- flow_val  in  1  flow id offered.
- flow_id  in  FLOW_ID_W  offered flow.
- flow_rdy  out  1  engine accepts flow.
- requeue_val  out  1  return cur_flowid to scheduler.
- requeue_rdy  in  1  requeue accepted.
- cur_flowid  out  FLOW_ID_W  address for all pointer, buffer and requeue traffic.
- rx_head_ptr  in  PTR_W+1  pointer memory read data, 1-cycle latency.
- rx_commit_ptr  in  PTR_W+1  pointer memory read data.
- tx_head_ptr  in  PTR_W+1  pointer memory read data.
- tx_tail_ptr  in  PTR_W+1  pointer memory read data.
- ptr_wr_val  out  1  single-cycle pointer update.
- ptr_wr_rx_head  out  PTR_W+1  new rx head.
- ptr_wr_tx_tail  out  PTR_W+1  new tx tail.
- rd_req_val  out  1  rx buffer read request.
- rd_req_rdy  in  1  accepted.
- rd_req_offset  out  PTR_W+1  rx byte offset.
- rd_req_size  out  16  bytes.
- rd_data_val  in  1  rx beat.
- rd_data_rdy  out  1  beat accepted.
- rd_data  in  DATA_W  beat.
- rd_data_last  in  1  final beat.
- wr_req_val  out  1  tx buffer write request.
- wr_req_rdy  in  1  accepted.
- wr_req_ptr  out  PTR_W+1  tx byte pointer.
- wr_req_size  out  16  bytes.
- wr_data_val  out  1  tx beat.
- wr_data_rdy  in  1  beat accepted.
- wr_data  out  DATA_W  beat.
- wr_data_last  out  1  final beat.
- wr_data_padbytes  out  log2(HB)  invalid bytes in final beat.

Function
REQ-003 SHALL transfer on val&rdy only; a val held SHALL keep its payload stable until accepted.

REQ-004 SHALL implement states:
- IDLE (flow_rdy=1): accept -> latch cur_flowid -> PTR.
- PTR (1 cycle): latch 4 pointers -> HDR_CHK.
- HDR_CHK: rx_used = commit-head (mod); rx_used<HB -> REQUEUE, else HDR_REQ.
- HDR_REQ: offset rx_head, size HB -> HDR_DATA.
- HDR_DATA: accept 1 beat; rd_len = rd_data[DATA_W-1 -: 16], wr_len = next 16 bits; out_len = ECHO_MODE ? rd_len : wr_len -> SAT_CHK.

REQ-005 SAT_CHK SHALL pass when (rx_used-HB)>=rd_len AND 2^PTR_W-(tail-head)>=out_len; fail -> REQUEUE with no pointer write; pass -> XFER_REQ.

REQ-006 XFER_REQ SHALL issue rd req (offset rx_head+HB, size rd_len) and wr req (ptr tx_tail, size out_len) independently; each is skipped when its length is 0; both done -> STREAM.

REQ-007 STREAM with ECHO_MODE=1: wr_data/val/last follow rd_data/val/last combinationally, and rd_data_rdy=wr_data_rdy.

REQ-008 STREAM with ECHO_MODE=0: rd_data_rdy=1 (discard); wr beats carry a constant pattern; a 16-bit bytes_left starts at wr_len, decrements HB per beat, last when bytes_left<=HB.

REQ-009 wr_data_padbytes SHALL be 0 when out_len mod HB==0, else HB-(out_len mod HB).

REQ-010 STREAM SHALL exit when every non-skipped side has seen its last beat -> UPDATE.

REQ-011 UPDATE SHALL pulse ptr_wr_val 1 cycle with rx_head+HB+rd_len and tx_tail+out_len (mod 2^(PTR_W+1)) -> REQUEUE.

REQ-012 REQUEUE SHALL hold requeue_val until requeue_rdy -> IDLE.

Reset
REQ-013 Async rst SHALL force IDLE, all *_val=0, rd_data_rdy=0, cur_flowid=0, lengths and counters 0; flow_rdy=1 after release.

REQ-014 Reset mid-operation SHALL abandon in-flight beats with no ptr_wr_val and no requeue.

Verification
REQ-015 Mode1, DATA_W=256, flow 5, rx 0/96, tx 0/0, rd_len 64 -> rd req (32,64), wr req (0,64), 2 beats copied, last on beat 2, padbytes 0, ptr_wr rx 96 / tx 64, requeue 5.

REQ-016 rx_used=16 -> no rd_req_val, requeue, no ptr_wr_val.

REQ-017 tail-head = 2^PTR_W-16, rd_len 40, used 72 -> header read, requeue, no ptr_wr_val.

REQ-018 Mode0, wr_len 40, rd_len 0 -> no payload rd req, 2 pattern beats, padbytes 24, ptr_wr rx +32 / tx +40.

REQ-019 rx_head = 2^(PTR_W+1)-32, rd_len 32 -> ptr_wr_rx_head = 32 (wrap); rst asserted in STREAM -> IDLE next cycle, no ptr_wr_val.
